rr_reg_write_arbiter: RTL and testbench

- Shares the write port of one W-bit storage register among N requesters, using round-robin priority.
- Each grant performs exactly one registered write of the winner's data into the register. The result is presented on q.
- Sits in front of the simple clocked d->q register datapath and replaces direct d driving when several sources must update it.

---
 rtl/rr_reg_write_arbiter.sv | 81 ++++++++
 tb/tb_rr_reg_write_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_reg_write_arbiter.sv
// rtl/rr_reg_write_arbiter.sv - round-robin arbiter for the write port of one W-bit register
// Optional RR_ARB_WRCNT_EN adds a saturating 16-bit write counter output wr_count.
module rr_reg_write_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   d_flat,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     q,
  output logic             wr,
`ifdef RR_ARB_WRCNT_EN
  output logic [15:0]      wr_count,
`endif
  output logic [IDW-1:0]   last_id
);

  logic [IDW-1:0] ptr;
  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] win;
  logic [W-1:0]   win_data;
  logic [N-1:0]   nxt_gnt;
  logic [IDW-1:0] nxt_ptr;

  // Last cycle's winner is masked so it cannot be written twice while it drops req.
  assign elig = req & ~gnt;

  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    nxt_gnt  = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && elig[idx]) begin
        found        = 1'b1;
        win          = IDW'(idx);
        win_data     = d_flat[idx*W +: W];
        nxt_gnt[idx] = 1'b1;
      end
    end
  end

  assign nxt_ptr = (int'(win) == N - 1) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      q       <= '0;
      wr      <= 1'b0;
      last_id <= '0;
      ptr     <= '0;
    end else if (found) begin
      gnt     <= nxt_gnt;
      q       <= win_data;
      wr      <= 1'b1;
      last_id <= win;
      ptr     <= nxt_ptr;
    end else begin
      gnt <= '0;
      wr  <= 1'b0;
    end
  end

`ifdef RR_ARB_WRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (found && wr_count != 16'hFFFF) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// tb/tb_rr_reg_write_arbiter.sv - self-checking bench for rr_reg_write_arbiter
module tb_rr_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   d_flat;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             wr;
  logic [IDW-1:0]   last_id;
`ifdef RR_ARB_WRCNT_EN
  logic [15:0]      wr_count;
`endif

  rr_reg_write_arbiter #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .d_flat(d_flat),
    .gnt(gnt),
    .q(q),
    .wr(wr),
`ifdef RR_ARB_WRCNT_EN
    .wr_count(wr_count),
`endif
    .last_id(last_id)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: winner index of the previous edge, pointer and stored value as integers.
  int m_ptr = 0;
  int m_prev = -1;
  int m_last = 0;
  int m_q = 0;
  int m_cnt = 0;

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dd);
    int win;
    win = -1;
    if (r) begin
      m_ptr = 0; m_prev = -1; m_q = 0; m_last = 0; m_cnt = 0;
    end else begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_ptr + off) % N;
        if (win < 0 && rq[idx] && idx != m_prev) win = idx;
      end
      m_prev = win;
      if (win >= 0) begin
        m_q = int'((dd >> (win * W)) & ((1 << W) - 1));
        m_last = win;
        m_ptr = (win + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(rst, req, d_flat);
    #1;
  endtask

  task automatic check_model();
    check("model_gnt", 32'(gnt), (m_prev >= 0) ? (32'd1 << m_prev) : 32'd0);
    check("model_q", 32'(q), m_q);
    check("model_wr", 32'(wr), (m_prev >= 0) ? 32'd1 : 32'd0);
    check("model_last_id", 32'(last_id), m_last);
    check("onehot_gnt", ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("wr_eq_or_gnt", 32'(wr), 32'(|gnt));
`ifdef RR_ARB_WRCNT_EN
    check("model_wr_count", 32'(wr_count), m_cnt);
`endif
  endtask

  typedef struct {
    logic            r;
    logic [N-1:0]    rq;
    logic [N*W-1:0]  d;
    logic [N-1:0]    eg;
    logic [W-1:0]    eq;
    logic            ew;
    logic [IDW-1:0]  el;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    req = '0;
    d_flat = '0;

    // reset, then all requesting with d_i = i+1
    tbl.push_back('{1'b1, 4'b0000, 16'h4321, 4'b0000, 4'h0, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0010, 4'h2, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0100, 4'h3, 1'b1, 2'd2});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b1000, 4'h4, 1'b1, 2'd3});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1, 2'd0});
    // reset mid-operation, next grant goes to requester 0
    tbl.push_back('{1'b1, 4'b1111, 16'h4321, 4'b0000, 4'h0, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 16'h4321, 4'b0001, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'b0000, 16'h4321, 4'b0000, 4'h1, 1'b0, 2'd0});
    // single held requester
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0001, 4'hA, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0000, 4'hA, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0001, 4'hA, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0000, 4'hA, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0001, 4'hA, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'b0001, 16'h432A, 4'b0000, 4'hA, 1'b0, 2'd0});
    // pointer wrap: requester 2 alone, then 3 and 0 held
    tbl.push_back('{1'b0, 4'b0100, 16'h9C7A, 4'b0100, 4'hC, 1'b1, 2'd2});
    tbl.push_back('{1'b0, 4'b1001, 16'h9C7A, 4'b1000, 4'h9, 1'b1, 2'd3});
    tbl.push_back('{1'b0, 4'b1001, 16'h9C7A, 4'b0001, 4'hA, 1'b1, 2'd0});
    // write 5, then idle hold
    tbl.push_back('{1'b0, 4'b0010, 16'h9C5A, 4'b0010, 4'h5, 1'b1, 2'd1});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'h5, 1'b0, 2'd1});

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      req = tbl[i].rq;
      d_flat = tbl[i].d;
      step();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].eg));
      check($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
      check($sformatf("vec%0d_wr", i), 32'(wr), 32'(tbl[i].ew));
      check($sformatf("vec%0d_last_id", i), 32'(last_id), 32'(tbl[i].el));
    end

    // randomized traffic against the model, with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      req = (i % 3 == 0) ? N'($urandom & $urandom) : N'($urandom);
      d_flat = (N*W)'($urandom);
      step();
      check_model();
    end

    // fairness: all requesting continuously, each requester within N+1 cycles
    rst = 1'b0;
    req = '1;
    begin
      int seen[N];
      for (int j = 0; j < N; j++) seen[j] = 0;
      for (int c = 0; c < N + 1; c++) begin
        step();
        for (int j = 0; j < N; j++) if (gnt[j]) seen[j] = 1;
      end
      for (int j = 0; j < N; j++) check($sformatf("fair_req%0d", j), 32'(seen[j]), 32'd1);
    end

`ifdef RR_ARB_WRCNT_EN
    rst = 1'b1;
    req = '0;
    step();
    check("cnt_reset", 32'(wr_count), 32'd0);
    rst = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 10; c++) step();
    check("cnt_10", 32'(wr_count), 32'd10);
    for (int c = 0; c < 65540; c++) step();
    check("cnt_sat", 32'(wr_count), 32'hFFFF);
    check_model();
    rst = 1'b1;
    step();
    check("cnt_rst", 32'(wr_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
